modbus_func_engine: RTL and testbench
=====================================

Name: modbus_func_engine

Overview:
- Parametrised successor to the fixed-map Modbus RTU function handler.
- Services FC 0x03 (read holding), 0x04 (read input) and 0x06 (write single) against configurable register windows.
- Produces Modbus exception codes 01–04, including a write-handshake timeout.
- Sits between the frame receiver/CRC checker and the response builder. Read data goes into the response DPRAM; tx_quantity, exception_out and resp_func_code drive the transmitter.

Parameters:
- N_HOLD, 4, number of holding registers (FC03 readable, FC06 writable), 1..64
- N_INPUT, 12, number of input registers (FC04 readable), 1..64
- HOLD_BASE, 16'h0001, Modbus address of holding register 0
- INPUT_BASE, 16'h0001, Modbus address of input register 0
- MAX_QTY, 125, largest legal read quantity
- DPRAM_AW, 8, response DPRAM address width; 2**DPRAM_AW >= MAX_QTY
- WR_TIMEOUT, 1024, clk cycles to wait for reg_w_done before raising exception 04

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- rx_message_done  in  1  one-cycle strobe: validated frame fields are present
- func_code  in  8  request function code
- addr  in  16  starting register address
- data  in  16  quantity (FC03/04) or write value (FC06)
- hold_regs  in  N_HOLD*16  flattened holding register values; reg k at [16k+15:16k]
- input_regs  in  N_INPUT*16  flattened input register values
- dpram_wen  out  1  response DPRAM write enable
- dpram_addr  out  DPRAM_AW  response DPRAM word address
- dpram_wdata  out  16  response DPRAM write data
- reg_wen  out  1  one-cycle write request to the register file
- reg_waddr  out  16  holding register index (addr - HOLD_BASE)
- reg_wdata  out  16  write value
- reg_w_done  in  1  write-complete strobe
- reg_w_status  in  1  sampled with reg_w_done; 1 = write failed
- tx_quantity  out  8  number of 16-bit words to transmit; 0 on exception
- exception_out  out  8  0 = normal response, else Modbus exception code
- resp_func_code  out  8  func_code, or func_code|8'h80 on exception
- handler_done  out  1  one-cycle strobe: outputs valid for the response builder
- busy  out  1  high from latch until handler_done

Behaviour:
- Reset: all outputs and internal registers are 0 and the state is IDLE. Reset mid-operation aborts immediately; no further DPRAM or register writes occur.
- States: IDLE, DECODE, READ, WR_REQ, WR_WAIT, DONE. Any illegal encoding goes to IDLE.
- IDLE: on rx_message_done, latch func_code, addr and data, set busy, go to DECODE.
- rx_message_done while busy is ignored; no queueing.
- DECODE (1 cycle): compute end = addr + qty in 17 bits so that wrap-around is illegal, never aliased.
  - Unsupported func_code -> exception 01.
  - FC03/04 with qty==0 or qty>MAX_QTY -> exception 03.
  - FC03/04 with addr < base or end > base + N -> exception 02.
  - FC06 with addr outside [HOLD_BASE, HOLD_BASE+N_HOLD) -> exception 02.
  - Any exception sets tx_quantity=0 and exception_out=code, then goes to DONE.
  - Otherwise FC03/04 -> READ and FC06 -> WR_REQ.
- READ: one word per cycle.
  - dpram_wen=1, dpram_addr=i, dpram_wdata=reg[addr-base+i] for i=0..qty-1.
  - Exactly qty writes, back-to-back.
  - After the last write, dpram_wen=0 and tx_quantity=qty, then go to DONE.
- WR_REQ: reg_wen=1 for exactly one cycle with reg_waddr and reg_wdata; clear the timeout counter; go to WR_WAIT.
- WR_WAIT:
  - reg_w_done with status 0 -> exception_out=0, tx_quantity=1, go to DONE.
  - reg_w_done with status 1 -> exception 04.
  - Counter reaches WR_TIMEOUT-1 without done -> exception 04.
  - If reg_w_done and timeout coincide, reg_w_done wins.
  - A late reg_w_done arriving in IDLE is ignored.
- DONE: handler_done=1 for one cycle, busy falls in the same cycle, return to IDLE.
  - tx_quantity, exception_out and resp_func_code hold until the next latch.
  - A new rx_message_done may be accepted on the cycle after DONE.
- Latency, with T0 = the cycle rx_message_done is sampled:
  - Exception: handler_done at T0+2.
  - Read of Q words: DPRAM writes T0+2..T0+Q+1, handler_done at T0+Q+2.
  - Write: reg_wen at T0+2, handler_done the cycle after reg_w_done.

Decomposition:
- Package modbus_pkg holds:
  - function codes FC_RD_HOLD=8'h03, FC_RD_INPUT=8'h04, FC_WR_SINGLE=8'h06;
  - exception codes EX_ILL_FUNC=1, EX_ILL_ADDR=2, EX_ILL_VAL=3, EX_DEV_FAIL=4;
  - EXC_FLAG=8'h80;
  - the state enum.
- One natural sub-module: modbus_range_check, purely combinational. It takes addr, qty, base and N and outputs addr_ok and qty_ok. It is instantiated twice, once per register window.

Test Plan:
- FC03, addr 1, qty 4, hold_regs = 1111/2222/3333/4444 -> four DPRAM writes at addresses 0..3 with that data; handler_done at T0+6; tx_quantity=4; exception_out=0.
- FC04, addr 12, qty 2 (N_INPUT=12) -> exception 02, no DPRAM write, resp_func_code=8'h84, tx_quantity=0. FC04, qty 0 -> exception 03.
- FC06, addr 2, data 16'hBEEF, reg_w_done+status 0 three cycles after reg_wen -> reg_waddr=1, reg_wdata=BEEF, tx_quantity=1, exception_out=0.
- FC06 with no reg_w_done -> exception 04 exactly WR_TIMEOUT cycles after reg_wen. Separately, reg_w_status=1 -> exception 04.
- FC 8'h05 -> exception 01, resp_func_code=8'h85. A second rx_message_done during a 10-word read is ignored.
- rst_n asserted mid-READ after 3 writes -> all outputs 0 at once, no further writes; a fresh FC03 after reset completes normally.

Source files
------------

// File: rtl/modbus_pkg.sv
// rtl/modbus_pkg.sv - function/exception codes and FSM state type for the Modbus function engine
package modbus_pkg;

    localparam logic [7:0] FC_RD_HOLD   = 8'h03;
    localparam logic [7:0] FC_RD_INPUT  = 8'h04;
    localparam logic [7:0] FC_WR_SINGLE = 8'h06;

    localparam logic [7:0] EX_ILL_FUNC = 8'd1;
    localparam logic [7:0] EX_ILL_ADDR = 8'd2;
    localparam logic [7:0] EX_ILL_VAL  = 8'd3;
    localparam logic [7:0] EX_DEV_FAIL = 8'd4;

    localparam logic [7:0] EXC_FLAG = 8'h80;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DECODE  = 3'd1,
        READ    = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/modbus_func_engine_if.sv
// rtl/modbus_func_engine_if.sv - request, DPRAM, register-write and response signals of the function engine
interface modbus_func_engine_if #(parameter int DPRAM_AW = 8);

    logic                rx_message_done;
    logic [7:0]          func_code;
    logic [15:0]         addr;
    logic [15:0]         data;

    logic                dpram_wen;
    logic [DPRAM_AW-1:0] dpram_addr;
    logic [15:0]         dpram_wdata;

    logic                reg_wen;
    logic [15:0]         reg_waddr;
    logic [15:0]         reg_wdata;
    logic                reg_w_done;
    logic                reg_w_status;

    logic [7:0]          tx_quantity;
    logic [7:0]          exception_out;
    logic [7:0]          resp_func_code;
    logic                handler_done;
    logic                busy;

    // master is the engine side
    modport master (
        input  rx_message_done, func_code, addr, data, reg_w_done, reg_w_status,
        output dpram_wen, dpram_addr, dpram_wdata, reg_wen, reg_waddr, reg_wdata,
        output tx_quantity, exception_out, resp_func_code, handler_done, busy
    );

    modport slave (
        output rx_message_done, func_code, addr, data, reg_w_done, reg_w_status,
        input  dpram_wen, dpram_addr, dpram_wdata, reg_wen, reg_waddr, reg_wdata,
        input  tx_quantity, exception_out, resp_func_code, handler_done, busy
    );

endinterface

// File: rtl/modbus_range_check.sv
// rtl/modbus_range_check.sv - combinational window and quantity check for one register window
module modbus_range_check #(
    parameter int MAX_QTY = 125
) (
    input  logic [15:0] addr,
    input  logic [15:0] qty,
    input  logic [15:0] base,
    input  logic [15:0] n,
    output logic        addr_ok,
    output logic        qty_ok
);

    logic [16:0] end_addr;
    logic [16:0] limit;

    // 17-bit sums so an address range wrapping past 16'hFFFF is rejected, not aliased
    assign end_addr = {1'b0, addr} + {1'b0, qty};
    assign limit    = {1'b0, base} + {1'b0, n};
    assign addr_ok  = (addr >= base) && (end_addr <= limit);
    assign qty_ok   = (qty != 16'd0) && (qty <= 16'(MAX_QTY));

endmodule

// File: rtl/modbus_func_engine.sv
// rtl/modbus_func_engine.sv - services FC03/04/06 against parametrised register windows with Modbus exceptions
module modbus_func_engine
    import modbus_pkg::*;
#(
    parameter int          N_HOLD     = 4,
    parameter int          N_INPUT    = 12,
    parameter logic [15:0] HOLD_BASE  = 16'h0001,
    parameter logic [15:0] INPUT_BASE = 16'h0001,
    parameter int          MAX_QTY    = 125,
    parameter int          DPRAM_AW   = 8,
    parameter int          WR_TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    modbus_func_engine_if.master    bus,
    input  logic [N_HOLD*16-1:0]    hold_regs,
    input  logic [N_INPUT*16-1:0]   input_regs
);

    state_t      state_q, state_d;
    logic [7:0]  fc_q, tx_q, exc_q, rfc_q, dec_exc;
    logic [15:0] addr_q, data_q, cnt_q, hold_qty, rd_off, rd_hold, rd_input, rd_word;
    logic [31:0] to_cnt_q;
    logic        hold_addr_ok, hold_qty_ok, in_addr_ok, in_qty_ok, last_word, to_expired;

    // FC06 reuses the holding-window check as a one-register range
    assign hold_qty = (fc_q == FC_WR_SINGLE) ? 16'd1 : data_q;

    modbus_range_check #(.MAX_QTY(MAX_QTY)) u_hold_chk (
        .addr(addr_q), .qty(hold_qty), .base(HOLD_BASE), .n(16'(N_HOLD)),
        .addr_ok(hold_addr_ok), .qty_ok(hold_qty_ok)
    );

    modbus_range_check #(.MAX_QTY(MAX_QTY)) u_input_chk (
        .addr(addr_q), .qty(data_q), .base(INPUT_BASE), .n(16'(N_INPUT)),
        .addr_ok(in_addr_ok), .qty_ok(in_qty_ok)
    );

    always_comb begin
        dec_exc = 8'd0;
        case (fc_q)
            FC_RD_HOLD: begin
                if (!hold_qty_ok)       dec_exc = EX_ILL_VAL;
                else if (!hold_addr_ok) dec_exc = EX_ILL_ADDR;
            end
            FC_RD_INPUT: begin
                if (!in_qty_ok)         dec_exc = EX_ILL_VAL;
                else if (!in_addr_ok)   dec_exc = EX_ILL_ADDR;
            end
            FC_WR_SINGLE: begin
                if (!hold_addr_ok)      dec_exc = EX_ILL_ADDR;
            end
            default: dec_exc = EX_ILL_FUNC;
        endcase
    end

    assign rd_off = addr_q - ((fc_q == FC_RD_HOLD) ? HOLD_BASE : INPUT_BASE) + cnt_q;

    always_comb begin
        rd_hold = 16'd0;
        for (int k = 0; k < N_HOLD; k++)
            if (rd_off == 16'(k)) rd_hold = hold_regs[k*16 +: 16];
    end

    always_comb begin
        rd_input = 16'd0;
        for (int k = 0; k < N_INPUT; k++)
            if (rd_off == 16'(k)) rd_input = input_regs[k*16 +: 16];
    end

    assign rd_word    = (fc_q == FC_RD_HOLD) ? rd_hold : rd_input;
    assign last_word  = (cnt_q == data_q - 16'd1);
    assign to_expired = (to_cnt_q == 32'(WR_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        bus.dpram_wen    = 1'b0;
        bus.dpram_addr   = '0;
        bus.dpram_wdata  = 16'd0;
        bus.reg_wen      = 1'b0;
        bus.reg_waddr    = 16'd0;
        bus.reg_wdata    = 16'd0;
        bus.handler_done = 1'b0;
        bus.busy         = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.rx_message_done) state_d = DECODE;
            end
            DECODE: begin
                bus.busy = 1'b1;
                if (dec_exc != 8'd0)            state_d = DONE;
                else if (fc_q == FC_WR_SINGLE)  state_d = WR_REQ;
                else                            state_d = READ;
            end
            READ: begin
                bus.busy        = 1'b1;
                bus.dpram_wen   = 1'b1;
                bus.dpram_addr  = cnt_q[DPRAM_AW-1:0];
                bus.dpram_wdata = rd_word;
                if (last_word) state_d = DONE;
            end
            WR_REQ: begin
                bus.busy      = 1'b1;
                bus.reg_wen   = 1'b1;
                bus.reg_waddr = addr_q - HOLD_BASE;
                bus.reg_wdata = data_q;
                state_d       = WR_WAIT;
            end
            WR_WAIT: begin
                bus.busy = 1'b1;
                if (bus.reg_w_done || to_expired) state_d = DONE;
            end
            DONE: begin
                bus.handler_done = 1'b1;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fc_q     <= 8'd0;
            addr_q   <= 16'd0;
            data_q   <= 16'd0;
            cnt_q    <= 16'd0;
            to_cnt_q <= 32'd0;
            tx_q     <= 8'd0;
            exc_q    <= 8'd0;
            rfc_q    <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.rx_message_done) begin
                        fc_q   <= bus.func_code;
                        addr_q <= bus.addr;
                        data_q <= bus.data;
                        cnt_q  <= 16'd0;
                        tx_q   <= 8'd0;
                        exc_q  <= 8'd0;
                        rfc_q  <= bus.func_code;
                    end
                end
                DECODE: begin
                    cnt_q <= 16'd0;
                    if (dec_exc != 8'd0) begin
                        exc_q <= dec_exc;
                        tx_q  <= 8'd0;
                        rfc_q <= fc_q | EXC_FLAG;
                    end
                end
                READ: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (last_word) tx_q <= data_q[7:0];
                end
                WR_REQ: to_cnt_q <= 32'd0;
                WR_WAIT: begin
                    // a done strobe in the same cycle as expiry takes priority
                    if (bus.reg_w_done) begin
                        if (bus.reg_w_status) begin
                            exc_q <= EX_DEV_FAIL;
                            rfc_q <= fc_q | EXC_FLAG;
                        end else begin
                            tx_q <= 8'd1;
                        end
                    end else if (to_expired) begin
                        exc_q <= EX_DEV_FAIL;
                        rfc_q <= fc_q | EXC_FLAG;
                    end else begin
                        to_cnt_q <= to_cnt_q + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.tx_quantity    = tx_q;
    assign bus.exception_out  = exc_q;
    assign bus.resp_func_code = rfc_q;

endmodule

// File: tb/tb_modbus_func_engine.sv
// tb/tb_modbus_func_engine.sv - randomized self-checking bench for modbus_func_engine against a behavioural model
module tb_modbus_func_engine;

    localparam int N_HOLD  = 4;
    localparam int N_INPUT = 12;
    localparam int HB      = 1;
    localparam int IB      = 1;
    localparam int MAX_QTY = 125;
    localparam int AW      = 8;
    localparam int WT      = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N_HOLD*16-1:0]  hold_regs  = '0;
    logic [N_INPUT*16-1:0] input_regs = '0;

    modbus_func_engine_if #(.DPRAM_AW(AW)) bus ();

    modbus_func_engine #(
        .N_HOLD(N_HOLD), .N_INPUT(N_INPUT), .HOLD_BASE(16'h0001), .INPUT_BASE(16'h0001),
        .MAX_QTY(MAX_QTY), .DPRAM_AW(AW), .WR_TIMEOUT(WT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .hold_regs(hold_regs), .input_regs(input_regs)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int exp_t0 = -1000, exp_nw = 0, exp_regw = -1, exp_done = -999;
    logic [7:0]  exp_tx = 0, exp_exc = 0, exp_rfc = 0, prev_tx = 0, prev_exc = 0, prev_rfc = 0;
    logic [15:0] exp_waddr = 0, exp_wdata = 0;
    logic [15:0] exp_words [128];
    bit cur_wr = 0;
    int cur_mode = 0, cur_dly = 0;

    logic [15:0] dp [256];
    int wr_count = 0, hd_count = 0, last_done_cyc = 0, last_regw_cyc = 0;
    logic [7:0]  last_tx = 0, last_exc = 0, last_rfc = 0;
    logic [15:0] last_waddr = 0, last_wdata = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: what a request must produce, from the window/quantity rules alone
    task automatic model(input logic [7:0] fc, input logic [15:0] a, input logic [15:0] d,
                         output int exc, output int nw);
        int base, n, ai, di;
        ai = int'(a);
        di = int'(d);
        exc = 0;
        nw = 0;
        if (fc == 8'h03 || fc == 8'h04) begin
            base = (fc == 8'h03) ? HB : IB;
            n    = (fc == 8'h03) ? N_HOLD : N_INPUT;
            if (di == 0 || di > MAX_QTY) exc = 3;
            else if (ai < base || ai + di > base + n) exc = 2;
            else begin
                nw = di;
                for (int k = 0; k < di; k++)
                    exp_words[k] = (fc == 8'h03) ? hold_regs[(ai-base+k)*16 +: 16]
                                                 : input_regs[(ai-base+k)*16 +: 16];
            end
        end else if (fc == 8'h06) begin
            if (ai < HB || ai >= HB + N_HOLD) exc = 2;
        end else begin
            exc = 1;
        end
    endtask

    task automatic start_req(input logic [7:0] fc, input logic [15:0] a, input logic [15:0] d,
                             input int mode, input int dly);
        int exc, nw;
        model(fc, a, d, exc, nw);
        prev_tx  = exp_tx;
        prev_exc = exp_exc;
        prev_rfc = exp_rfc;
        exp_t0   = cyc;
        exp_nw   = nw;
        exp_regw = -1;
        cur_wr   = (exc == 0 && fc == 8'h06);
        cur_mode = mode;
        cur_dly  = dly;
        exp_waddr = a - 16'(HB);
        exp_wdata = d;
        if (exc != 0) begin
            exp_done = cyc + 2; exp_tx = 0; exp_exc = 8'(exc);
        end else if (fc != 8'h06) begin
            exp_done = cyc + nw + 2; exp_tx = 8'(nw); exp_exc = 0;
        end else begin
            exp_regw = cyc + 2;
            if (mode == 2) begin
                exp_done = exp_regw + WT + 1; exp_exc = 4; exp_tx = 0;
            end else begin
                exp_done = exp_regw + dly + 1;
                exp_exc  = (mode == 1) ? 8'd4 : 8'd0;
                exp_tx   = (mode == 1) ? 8'd0 : 8'd1;
            end
        end
        exp_rfc = (exp_exc != 0) ? (fc | 8'h80) : fc;
        bus.func_code = fc;
        bus.addr = a;
        bus.data = d;
        bus.rx_message_done = 1'b1;
        @(posedge clk); #1;
        bus.rx_message_done = 1'b0;
    endtask

    task automatic finish_req();
        if (cur_wr && cur_mode != 2) begin
            while (cyc < exp_regw + cur_dly) begin @(posedge clk); #1; end
            bus.reg_w_done = 1'b1;
            bus.reg_w_status = (cur_mode == 1);
            @(posedge clk); #1;
            bus.reg_w_done = 1'b0;
            bus.reg_w_status = 1'b0;
        end
        while (cyc <= exp_done) begin @(posedge clk); #1; end
    endtask

    task automatic rand_regs();
        for (int k = 0; k < N_HOLD; k++)  hold_regs[k*16 +: 16]  = 16'($urandom);
        for (int k = 0; k < N_INPUT; k++) input_regs[k*16 +: 16] = 16'($urandom);
    endtask

    // Cycle-by-cycle comparison of every output against the current expectation
    always @(negedge clk) begin : cmp
        int i;
        bit exp_wen;
        if (!rst_n) begin
            chk("rst_strobes", {bus.dpram_wen, bus.reg_wen, bus.handler_done, bus.busy}, 0);
            chk("rst_resp", {bus.tx_quantity, bus.exception_out, bus.resp_func_code}, 0);
            chk("rst_dpram", {bus.dpram_addr, bus.dpram_wdata}, 0);
            chk("rst_reg", {bus.reg_waddr, bus.reg_wdata}, 0);
        end else begin
            i = cyc - exp_t0 - 2;
            exp_wen = (i >= 0 && i < exp_nw);
            chk("dpram_wen", bus.dpram_wen, exp_wen);
            if (exp_wen && bus.dpram_wen) begin
                chk("dpram_addr", bus.dpram_addr, i);
                chk("dpram_wdata", bus.dpram_wdata, exp_words[i]);
            end
            chk("reg_wen", bus.reg_wen, cyc == exp_regw);
            if (cyc == exp_regw && bus.reg_wen) begin
                chk("reg_waddr", bus.reg_waddr, exp_waddr);
                chk("reg_wdata", bus.reg_wdata, exp_wdata);
            end
            chk("handler_done", bus.handler_done, cyc == exp_done);
            chk("busy", bus.busy, cyc > exp_t0 && cyc < exp_done);
            if (cyc <= exp_t0) begin
                chk("hold_tx", bus.tx_quantity, prev_tx);
                chk("hold_exc", bus.exception_out, prev_exc);
                chk("hold_rfc", bus.resp_func_code, prev_rfc);
            end else if (cyc >= exp_done) begin
                chk("tx_quantity", bus.tx_quantity, exp_tx);
                chk("exception_out", bus.exception_out, exp_exc);
                chk("resp_func_code", bus.resp_func_code, exp_rfc);
            end
            if (bus.dpram_wen) begin
                dp[bus.dpram_addr] = bus.dpram_wdata;
                wr_count++;
            end
            if (bus.reg_wen) begin
                last_regw_cyc = cyc;
                last_waddr = bus.reg_waddr;
                last_wdata = bus.reg_wdata;
            end
            if (bus.handler_done) begin
                hd_count++;
                last_done_cyc = cyc;
                last_tx  = bus.tx_quantity;
                last_exc = bus.exception_out;
                last_rfc = bus.resp_func_code;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int wc0, hd0;
        bus.rx_message_done = 1'b0;
        bus.func_code = 8'h00;
        bus.addr = 16'h0000;
        bus.data = 16'h0000;
        bus.reg_w_done = 1'b0;
        bus.reg_w_status = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        hold_regs = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        wc0 = wr_count;
        start_req(8'h03, 16'd1, 16'd4, 0, 0);
        finish_req();
        chk("lit_rd_latency", last_done_cyc - exp_t0, 6);
        chk("lit_rd_count", wr_count - wc0, 4);
        chk("lit_rd_w0", dp[0], 16'h1111);
        chk("lit_rd_w3", dp[3], 16'h4444);
        chk("lit_rd_tx", last_tx, 4);
        chk("lit_rd_exc", last_exc, 0);

        rand_regs();
        wc0 = wr_count;
        start_req(8'h04, 16'd12, 16'd2, 0, 0);
        finish_req();
        chk("lit_fc04_rfc", last_rfc, 8'h84);
        chk("lit_fc04_exc", last_exc, 2);
        chk("lit_fc04_tx", last_tx, 0);
        chk("lit_fc04_nowrite", wr_count - wc0, 0);
        chk("lit_exc_latency", last_done_cyc - exp_t0, 2);

        start_req(8'h04, 16'd1, 16'd0, 0, 0);
        finish_req();
        chk("lit_qty0_exc", last_exc, 3);

        start_req(8'h03, 16'hFFFF, 16'd2, 0, 0);
        finish_req();
        chk("lit_wrap_exc", last_exc, 2);

        start_req(8'h06, 16'd2, 16'hBEEF, 0, 3);
        finish_req();
        chk("lit_wr_waddr", last_waddr, 1);
        chk("lit_wr_wdata", last_wdata, 16'hBEEF);
        chk("lit_wr_tx", last_tx, 1);
        chk("lit_wr_exc", last_exc, 0);
        chk("lit_wr_latency", last_done_cyc - last_regw_cyc, 4);

        start_req(8'h06, 16'd3, 16'h1234, 2, 0);
        finish_req();
        chk("lit_to_exc", last_exc, 4);
        chk("lit_to_latency", last_done_cyc - last_regw_cyc, WT + 1);
        hd0 = hd_count;
        bus.reg_w_done = 1'b1;
        @(posedge clk); #1;
        bus.reg_w_done = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("lit_late_done_ignored", hd_count - hd0, 0);

        start_req(8'h06, 16'd4, 16'h5555, 1, 2);
        finish_req();
        chk("lit_status_exc", last_exc, 4);

        start_req(8'h06, 16'd1, 16'h0A0A, 0, WT);
        finish_req();
        chk("lit_coincide_exc", last_exc, 0);

        start_req(8'h05, 16'd1, 16'd1, 0, 0);
        finish_req();
        chk("lit_fc05_rfc", last_rfc, 8'h85);
        chk("lit_fc05_exc", last_exc, 1);

        rand_regs();
        start_req(8'h04, 16'd1, 16'd10, 0, 0);
        while (cyc < exp_t0 + 5) begin @(posedge clk); #1; end
        bus.func_code = 8'h03;
        bus.addr = 16'd1;
        bus.data = 16'd1;
        bus.rx_message_done = 1'b1;
        @(posedge clk); #1;
        bus.rx_message_done = 1'b0;
        finish_req();
        chk("lit_busy_rx_tx", last_tx, 10);

        wc0 = wr_count;
        start_req(8'h04, 16'd1, 16'd10, 0, 0);
        while (cyc < exp_t0 + 5) begin @(posedge clk); #1; end
        exp_t0 = -1000; exp_nw = 0; exp_regw = -1; exp_done = -999;
        exp_tx = 0; exp_exc = 0; exp_rfc = 0;
        prev_tx = 0; prev_exc = 0; prev_rfc = 0;
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("lit_abort_writes", wr_count - wc0, 3);

        rand_regs();
        start_req(8'h03, 16'd1, 16'd4, 0, 0);
        finish_req();
        chk("lit_after_reset_tx", last_tx, 4);

        for (int n = 0; n < 60; n++) begin
            logic [7:0]  fc;
            logic [15:0] a, d;
            int r, mode, dly;
            rand_regs();
            r = $urandom_range(0, 9);
            fc = (r < 4) ? 8'h03 : (r < 7) ? 8'h04 : (r < 9) ? 8'h06 : 8'($urandom);
            a = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 14));
            case ($urandom_range(0, 6))
                0: d = 16'd0;
                1: d = 16'd126;
                2: d = 16'hFFFF;
                3: d = 16'd125;
                default: d = 16'($urandom_range(1, 13));
            endcase
            if (fc == 8'h06) d = 16'($urandom);
            mode = ($urandom_range(0, 24) == 0) ? 2 : (($urandom_range(0, 3) == 0) ? 1 : 0);
            dly = $urandom_range(1, 6);
            start_req(fc, a, d, mode, dly);
            finish_req();
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
